// File: rtl/eth_parser_pkg.sv
// ---------------------------------------------------------------------------
// eth_parser_pkg
// Shared types and constants for the Ethernet L2 parser pipeline.
//   mac_addr_t      : 48-bit MAC address
//   ethertype_t     : 16-bit EtherType
//   eth_metadata_t  : packed bundle of every field the metadata packager
//                     publishes downstream
//   pkgr_state_t    : frame-tracking state of the metadata packager
// ---------------------------------------------------------------------------
package eth_parser_pkg;

    typedef logic [47:0] mac_addr_t;
    typedef logic [15:0] ethertype_t;

    localparam ethertype_t ETH_TYPE_IPV4 = 16'h0800;
    localparam ethertype_t ETH_TYPE_IPV6 = 16'h86DD;
    localparam ethertype_t ETH_TYPE_ARP  = 16'h0806;

    localparam logic [4:0] L2_HDR_LEN_UNTAGGED = 5'd14;
    localparam logic [4:0] L2_HDR_LEN_TAGGED   = 5'd18;

    typedef struct packed {
        mac_addr_t  dest_mac;
        mac_addr_t  src_mac;
        ethertype_t ethertype;
        logic       vlan_present;
        logic [11:0] vlan_id;
        logic [4:0] l2_header_len;
        logic       is_ipv4;
        logic       is_ipv6;
        logic       is_arp;
        logic       is_unknown;
    } eth_metadata_t;

    // IDLE  : not inside a frame (armed = 0)
    // ARMED : inside a frame, metadata not yet sent
    // SENT  : inside a frame, metadata already sent
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_SENT  = 2'd2
    } pkgr_state_t;

    // Same header fields, class bits replaced by "unknown" for frames that
    // ended before the classifier produced a verdict.
    function automatic eth_metadata_t force_unknown(input eth_metadata_t m);
        eth_metadata_t r;
        r            = m;
        r.is_ipv4    = 1'b0;
        r.is_ipv6    = 1'b0;
        r.is_arp     = 1'b0;
        r.is_unknown = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/metadata_packager.sv
// ---------------------------------------------------------------------------
// metadata_packager
// Final stage of the Ethernet L2 parser. Snapshots the parsed header fields
// into stable registers and emits exactly one single-cycle metadata_valid
// pulse per frame.
//
// Ports
//   clk, rst_n              parser clock / async active-low reset
//   frame_start, frame_end  one-cycle frame delimiters
//   dest_mac, src_mac, resolved_ethertype, vlan_present, vlan_id,
//   l2_header_len           parsed header fields
//   proto_valid             classifier verdict strobe
//   is_ipv4/ipv6/arp/unknown one-hot protocol class
//   meta_*                  registered copies, held until the next capture
//   metadata_valid          one-cycle pulse, meta_* valid on that cycle
// ---------------------------------------------------------------------------
module metadata_packager
    import eth_parser_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic        frame_end,
    input  mac_addr_t   dest_mac,
    input  mac_addr_t   src_mac,
    input  ethertype_t  resolved_ethertype,
    input  logic        vlan_present,
    input  logic [11:0] vlan_id,
    input  logic [4:0]  l2_header_len,
    input  logic        proto_valid,
    input  logic        is_ipv4,
    input  logic        is_ipv6,
    input  logic        is_arp,
    input  logic        is_unknown,
    output mac_addr_t   meta_dest_mac,
    output mac_addr_t   meta_src_mac,
    output ethertype_t  meta_ethertype,
    output logic        meta_vlan_present,
    output logic [11:0] meta_vlan_id,
    output logic [4:0]  meta_l2_header_len,
    output logic        meta_is_ipv4,
    output logic        meta_is_ipv6,
    output logic        meta_is_arp,
    output logic        meta_is_unknown,
    output logic        metadata_valid
);

    pkgr_state_t   state_q, state_d;
    eth_metadata_t meta_q,  meta_d;
    logic          valid_q, valid_d;

    eth_metadata_t fields_in;
    logic          armed_now;
    logic          sent_now;
    logic          capture;
    logic          fallback;

    assign fields_in = '{
        dest_mac:      dest_mac,
        src_mac:       src_mac,
        ethertype:     resolved_ethertype,
        vlan_present:  vlan_present,
        vlan_id:       vlan_id,
        l2_header_len: l2_header_len,
        is_ipv4:       is_ipv4,
        is_ipv6:       is_ipv6,
        is_arp:        is_arp,
        is_unknown:    is_unknown
    };

    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves one unassigned, which would infer a latch.
        state_d   = state_q;
        meta_d    = meta_q;
        valid_d   = 1'b0;
        armed_now = 1'b0;
        sent_now  = 1'b0;

        unique case (state_q)
            ST_IDLE:  begin armed_now = 1'b0; sent_now = 1'b0; end
            ST_ARMED: begin armed_now = 1'b1; sent_now = 1'b0; end
            ST_SENT:  begin armed_now = 1'b1; sent_now = 1'b1; end
            default:  begin armed_now = 1'b0; sent_now = 1'b0; end
        endcase

        // frame_start acts before anything else on the same edge: it arms
        // the packager and discards whatever the previous frame left behind.
        if (frame_start) begin
            armed_now = 1'b1;
            sent_now  = 1'b0;
        end

        capture  = proto_valid && armed_now && !sent_now;
        fallback = !capture && frame_end && armed_now && !sent_now;

        if (capture) begin
            meta_d  = fields_in;
            valid_d = 1'b1;
        end else if (fallback) begin
            meta_d  = force_unknown(fields_in);
            valid_d = 1'b1;
        end

        if (frame_end || !armed_now) begin
            state_d = ST_IDLE;
        end else if (capture || sent_now) begin
            state_d = ST_SENT;
        end else begin
            state_d = ST_ARMED;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (!rst_n) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            meta_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            meta_q  <= meta_d;
        end
    end

    assign meta_dest_mac      = meta_q.dest_mac;
    assign meta_src_mac       = meta_q.src_mac;
    assign meta_ethertype     = meta_q.ethertype;
    assign meta_vlan_present  = meta_q.vlan_present;
    assign meta_vlan_id       = meta_q.vlan_id;
    assign meta_l2_header_len = meta_q.l2_header_len;
    assign meta_is_ipv4       = meta_q.is_ipv4;
    assign meta_is_ipv6       = meta_q.is_ipv6;
    assign meta_is_arp        = meta_q.is_arp;
    assign meta_is_unknown    = meta_q.is_unknown;
    assign metadata_valid     = valid_q;

endmodule

// File: tb/tb_metadata_packager.sv
// ---------------------------------------------------------------------------
// tb_metadata_packager
// Directed scenarios followed by a randomized frame stream, each cycle
// compared against a frame-level reference model of the packager.
// ---------------------------------------------------------------------------
module tb_metadata_packager;
    import eth_parser_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic frame_start, frame_end, proto_valid;
    eth_metadata_t drv;

    mac_addr_t   meta_dest_mac, meta_src_mac;
    ethertype_t  meta_ethertype;
    logic        meta_vlan_present;
    logic [11:0] meta_vlan_id;
    logic [4:0]  meta_l2_header_len;
    logic        meta_is_ipv4, meta_is_ipv6, meta_is_arp, meta_is_unknown;
    logic        metadata_valid;

    int checks   = 0;
    int failures = 0;

    // Reference model: frame-level view of the packager.
    logic          m_in_frame;
    logic          m_sent;
    logic          m_pulse;
    eth_metadata_t m_meta;

    always #5 clk = ~clk;

    metadata_packager dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .frame_start        (frame_start),
        .frame_end          (frame_end),
        .dest_mac           (drv.dest_mac),
        .src_mac            (drv.src_mac),
        .resolved_ethertype (drv.ethertype),
        .vlan_present       (drv.vlan_present),
        .vlan_id            (drv.vlan_id),
        .l2_header_len      (drv.l2_header_len),
        .proto_valid        (proto_valid),
        .is_ipv4            (drv.is_ipv4),
        .is_ipv6            (drv.is_ipv6),
        .is_arp             (drv.is_arp),
        .is_unknown         (drv.is_unknown),
        .meta_dest_mac      (meta_dest_mac),
        .meta_src_mac       (meta_src_mac),
        .meta_ethertype     (meta_ethertype),
        .meta_vlan_present  (meta_vlan_present),
        .meta_vlan_id       (meta_vlan_id),
        .meta_l2_header_len (meta_l2_header_len),
        .meta_is_ipv4       (meta_is_ipv4),
        .meta_is_ipv6       (meta_is_ipv6),
        .meta_is_arp        (meta_is_arp),
        .meta_is_unknown    (meta_is_unknown),
        .metadata_valid     (metadata_valid)
    );

    function automatic eth_metadata_t observed();
        eth_metadata_t o;
        o.dest_mac      = meta_dest_mac;
        o.src_mac       = meta_src_mac;
        o.ethertype     = meta_ethertype;
        o.vlan_present  = meta_vlan_present;
        o.vlan_id       = meta_vlan_id;
        o.l2_header_len = meta_l2_header_len;
        o.is_ipv4       = meta_is_ipv4;
        o.is_ipv6       = meta_is_ipv6;
        o.is_arp        = meta_is_arp;
        o.is_unknown    = meta_is_unknown;
        return o;
    endfunction

    task automatic check(input string tag, input logic [133:0] obs, input logic [133:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        frame_start = 1'b0;
        frame_end   = 1'b0;
        proto_valid = 1'b0;
    endtask

    task automatic model_reset();
        m_in_frame = 1'b0;
        m_sent     = 1'b0;
        m_pulse    = 1'b0;
        m_meta     = '0;
    endtask

    // Apply the frame rules for one clock edge using the inputs presently driven.
    task automatic model_edge();
        bit in_frame, sent, take, late;
        in_frame = m_in_frame;
        sent     = m_sent;
        if (frame_start) begin
            in_frame = 1'b1;
            sent     = 1'b0;
        end
        take = proto_valid && in_frame && !sent;
        late = !take && frame_end && in_frame && !sent;
        m_pulse = take || late;
        if (take) m_meta = drv;
        if (late) begin
            m_meta            = drv;
            m_meta.is_ipv4    = 1'b0;
            m_meta.is_ipv6    = 1'b0;
            m_meta.is_arp     = 1'b0;
            m_meta.is_unknown = 1'b1;
        end
        if (take || late) sent = 1'b1;
        if (frame_end) in_frame = 1'b0;
        m_in_frame = in_frame;
        m_sent     = sent;
    endtask

    // One clock: model the edge, then compare shortly after it.
    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check({tag, "_valid"}, {133'd0, metadata_valid}, {133'd0, m_pulse});
        check({tag, "_meta"}, observed(), m_meta);
    endtask

    function automatic eth_metadata_t rand_fields();
        eth_metadata_t f;
        int cls;
        f.dest_mac     = {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF;
        f.src_mac      = {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF;
        f.vlan_present = 1'($urandom_range(0, 1));
        f.vlan_id      = 12'($urandom);
        f.l2_header_len = f.vlan_present ? L2_HDR_LEN_TAGGED : L2_HDR_LEN_UNTAGGED;
        cls = $urandom_range(0, 3);
        f.is_ipv4    = (cls == 0);
        f.is_ipv6    = (cls == 1);
        f.is_arp     = (cls == 2);
        f.is_unknown = (cls == 3);
        f.ethertype  = (cls == 0) ? ETH_TYPE_IPV4 :
                       (cls == 1) ? ETH_TYPE_IPV6 :
                       (cls == 2) ? ETH_TYPE_ARP  : 16'($urandom);
        return f;
    endfunction

    initial begin
        set_idle();
        drv   = '0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", {133'd0, metadata_valid}, 134'd0);
        check("reset_meta", observed(), 134'd0);
        rst_n = 1'b1;

        // proto_valid with no frame_start since reset: ignored.
        drv = '0;
        drv.dest_mac = 48'h111111111111;
        drv.is_ipv4  = 1'b1;
        proto_valid = 1'b1;
        step("unarmed");
        check("unarmed_dest", {86'd0, meta_dest_mac}, 134'd0);
        set_idle();
        step("unarmed_idle");

        // Basic untagged IPv4 frame.
        frame_start = 1'b1;
        step("f1_start");
        set_idle();
        drv = '0;
        drv.dest_mac      = 48'hAABBCCDDEEFF;
        drv.src_mac       = 48'h001122334455;
        drv.ethertype     = ETH_TYPE_IPV4;
        drv.l2_header_len = L2_HDR_LEN_UNTAGGED;
        drv.is_ipv4       = 1'b1;
        proto_valid = 1'b1;
        step("f1_cap");
        check("f1_pulse", {133'd0, metadata_valid}, {133'd0, 1'b1});
        check("f1_dest", {86'd0, meta_dest_mac}, {86'd0, 48'hAABBCCDDEEFF});
        check("f1_type", {118'd0, meta_ethertype}, {118'd0, 16'h0800});
        check("f1_len", {129'd0, meta_l2_header_len}, {129'd0, 5'd14});
        set_idle();
        step("f1_after");
        check("f1_single", {133'd0, metadata_valid}, 134'd0);

        // Second proto_valid in the same frame is ignored.
        drv.dest_mac = 48'h999999999999;
        proto_valid = 1'b1;
        step("f1_dup");
        check("f1_dup_dest", {86'd0, meta_dest_mac}, {86'd0, 48'hAABBCCDDEEFF});
        set_idle();
        frame_end = 1'b1;
        step("f1_end");
        set_idle();

        // Tagged IPv6 frame, frame_start and proto_valid together.
        drv = '0;
        drv.dest_mac      = 48'h0A0B0C0D0E0F;
        drv.src_mac       = 48'h102030405060;
        drv.ethertype     = ETH_TYPE_IPV6;
        drv.vlan_present  = 1'b1;
        drv.vlan_id       = 12'h064;
        drv.l2_header_len = L2_HDR_LEN_TAGGED;
        drv.is_ipv6       = 1'b1;
        frame_start = 1'b1;
        proto_valid = 1'b1;
        step("f2_cap");
        check("f2_vid", {122'd0, meta_vlan_id}, {122'd0, 12'h064});
        check("f2_ipv6", {133'd0, meta_is_ipv6}, {133'd0, 1'b1});
        set_idle();
        frame_end = 1'b1;
        step("f2_end");
        set_idle();

        // Frame without a classifier verdict: fallback emit on frame_end.
        frame_start = 1'b1;
        step("f3_start");
        set_idle();
        step("f3_mid");
        drv = rand_fields();
        drv.is_ipv4 = 1'b1; drv.is_ipv6 = 1'b0; drv.is_arp = 1'b0; drv.is_unknown = 1'b0;
        frame_end = 1'b1;
        step("f3_end");
        check("f3_unknown", {130'd0, meta_is_ipv4, meta_is_ipv6, meta_is_arp, meta_is_unknown},
              {130'd0, 4'b0001});
        set_idle();
        step("f3_after");

        // Reset between frame_start and proto_valid.
        frame_start = 1'b1;
        step("f4_start");
        set_idle();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_mid_valid", {133'd0, metadata_valid}, 134'd0);
        check("rst_mid_meta", observed(), 134'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drv = rand_fields();
        proto_valid = 1'b1;
        step("f4_after_rst");
        set_idle();

        // Randomized frame stream.
        for (int i = 0; i < 2000; i++) begin
            drv         = rand_fields();
            frame_start = ($urandom_range(0, 5) == 0);
            frame_end   = ($urandom_range(0, 5) == 0);
            proto_valid = ($urandom_range(0, 3) == 0);
            step("rand");
        end
        set_idle();
        step("rand_tail");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
